// File: rtl/reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_bank_pkg                                               |
// | Brief    : Shared constants, address-range helper and read-port       |
// |            select function for the reg_bank register file.           |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package reg_bank_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Which source a read port presents on its outputs.
  typedef struct packed {
    logic use_word;     // stored word and its valid bit
    logic use_wdata;    // forwarded write data, valid forced high
    logic force_valid;  // hard-wired zero word: data 0, valid 1
  } rd_sel_t;

  // True when addr names a physically present word.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

  // Zero register outranks forwarding, forwarding outranks storage;
  // anything else (out of range) reads as 0 / invalid.
  function automatic rd_sel_t read_sel(input logic in_range, input logic zero_hit,
                                       input logic fwd_hit);
    rd_sel_t sel;
    sel = '0;
    if (zero_hit) begin
      sel.force_valid = 1'b1;
    end else if (fwd_hit) begin
      sel.use_wdata = 1'b1;
    end else if (in_range) begin
      sel.use_word = 1'b1;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_word                                                   |
// | Brief    : One WIDTH-bit storage word with load enable, synchronous   |
// |            clear and asynchronous active-low reset.                  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module reg_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next value: clear beats load, otherwise hold.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = d;
    end
  end

  // Storage flop with immediate reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign q = value_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_bank                                                   |
// | Brief    : DEPTH x WIDTH register file, one synchronous write port,   |
// |            two combinational read ports, per-word valid tracking,    |
// |            optional hard-wired zero word.                            |
// |            Build macro REG_BANK_BYPASS_EN adds same-cycle write-to-   |
// |            read forwarding.                                          |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  bit ZERO_REG = 1'b0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b
);

`ifdef REG_BANK_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  logic [WIDTH-1:0] word_val [DEPTH];
  logic [DEPTH-1:0] wen_vec;
  logic             we_ok;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  logic [AW-1:0]    raddr     [2];
  logic [WIDTH-1:0] word_sel  [2];
  logic             vld_sel   [2];
  logic             in_range  [2];
  logic             zero_hit  [2];
  logic             fwd_hit   [2];
  rd_sel_t          sel       [2];
  logic [WIDTH-1:0] rdata_v   [2];
  logic             rvalid_v  [2];

  // One-hot word enable; out-of-range addresses and the zero word match nothing.
  always_comb begin
    wen_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wen_vec[i] = we && !clr && (waddr == AW'(i)) && !(ZERO_REG && (i == 0));
    end
    we_ok = |wen_vec;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      if (ZERO_REG && (gi == 0)) begin : g_zero
        assign word_val[gi] = '0;
      end else begin : g_reg
        reg_word #(.WIDTH(WIDTH)) u_word (
          .clk   (clk),
          .rst_n (rst_n),
          .clr   (clr),
          .en    (wen_vec[gi]),
          .d     (wdata),
          .q     (word_val[gi])
        );
      end
    end
  endgenerate

  // Valid bits: clear wipes all, an accepted write marks its word.
  always_comb begin
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else begin
      valid_d = valid_q | wen_vec;
    end
  end

  // Valid vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  // Both read ports: look up the word, then pick storage / forward / zero.
  // Forwarding is gated by rst_n so reset always reads back as zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      word_sel[p] = '0;
      vld_sel[p]  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr[p] == AW'(i)) begin
          word_sel[p] = word_val[i];
          vld_sel[p]  = valid_q[i];
        end
      end
      in_range[p] = addr_in_range(32'(raddr[p]), DEPTH);
      zero_hit[p] = ZERO_REG && (raddr[p] == '0);
      fwd_hit[p]  = BYPASS_EN && rst_n && we_ok && (raddr[p] == waddr);
      sel[p]      = read_sel(in_range[p], zero_hit[p], fwd_hit[p]);
      rdata_v[p]  = sel[p].use_wdata ? wdata : (sel[p].use_word ? word_sel[p] : '0);
      rvalid_v[p] = sel[p].force_valid | sel[p].use_wdata | (sel[p].use_word & vld_sel[p]);
    end
  end

  assign rdata_a  = rdata_v[0];
  assign rdata_b  = rdata_v[1];
  assign rvalid_a = rvalid_v[0];
  assign rvalid_b = rvalid_v[1];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_reg_bank                                                |
// | Brief    : Self-checking bench for reg_bank. Three instances share    |
// |            stimulus: 8x8 plain, 8x8 with zero word, 6x8 plain.       |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int NCFG = 3;
  int cfg_depth [NCFG] = '{8, 8, 6};
  bit cfg_zr    [NCFG] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n, clr, we;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] rd_a [NCFG];
  logic [7:0] rd_b [NCFG];
  logic       va   [NCFG];
  logic       vb   [NCFG];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[0]), .rdata_b(rd_b[0]),
    .rvalid_a(va[0]), .rvalid_b(vb[0]));

  reg_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[1]), .rdata_b(rd_b[1]),
    .rvalid_a(va[1]), .rvalid_b(vb[1]));

  reg_bank #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b0)) dut_d6 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[2]), .rdata_b(rd_b[2]),
    .rvalid_a(va[2]), .rvalid_b(vb[2]));

  // ---------------- reference model ----------------
  logic [7:0] m_mem [NCFG][8];
  bit         m_vld [NCFG][8];

  function automatic bit accepted(int c, logic [2:0] a);
    return (int'(a) < cfg_depth[c]) && !(cfg_zr[c] && a == 3'd0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      for (int c = 0; c < NCFG; c++)
        for (int i = 0; i < 8; i++) begin
          m_mem[c][i] <= 8'h00;
          m_vld[c][i] <= 1'b0;
        end
    end else if (we) begin
      for (int c = 0; c < NCFG; c++)
        if (accepted(c, waddr)) begin
          m_mem[c][waddr] <= wdata;
          m_vld[c][waddr] <= 1'b1;
        end
    end
  end

  // Expected {valid, data} seen on a read port right now.
  function automatic logic [8:0] exp_read(int c, logic [2:0] a);
    if (cfg_zr[c] && a == 3'd0)            return {1'b1, 8'h00};
    if (int'(a) >= cfg_depth[c])           return {1'b0, 8'h00};
    if (BYP && rst_n && we && !clr && a == waddr) return {1'b1, wdata};
    return {m_vld[c][a], m_mem[c][a]};
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got valid=%0b data=%02h, expected valid=%0b data=%02h",
               name, act[8], act[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cmp_a cfg%0d addr%0d", c, raddr_a), {va[c], rd_a[c]}, exp_read(c, raddr_a));
      check($sformatf("cmp_b cfg%0d addr%0d", c, raddr_b), {vb[c], rd_b[c]}, exp_read(c, raddr_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; clr = 1'b0; we = 1'b0;
    waddr = 3'd0; wdata = 8'h00; raddr_a = 3'd3; raddr_b = 3'd0;

    // Async reset with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_a_plain", {va[0], rd_a[0]}, 9'h000);
    check("rst_b_plain", {vb[0], rd_b[0]}, 9'h000);
    check("rst_b_zero",  {vb[1], rd_b[1]}, 9'h100);
    step(); step();
    step(); rst_n = 1'b1;

    // Write 0xA5 to addr 3.
    step(); we = 1'b1; waddr = 3'd3; wdata = 8'hA5; raddr_a = 3'd3;
    #2 check("wr_same_cycle", {va[0], rd_a[0]}, BYP ? 9'h1A5 : 9'h000);
    step(); we = 1'b0;
    #2 check("wr_next_cycle", {va[0], rd_a[0]}, 9'h1A5);

    // Dual port.
    step(); we = 1'b1; waddr = 3'd1; wdata = 8'h11;
    step(); waddr = 3'd6; wdata = 8'h22;
    step(); we = 1'b0; raddr_a = 3'd1; raddr_b = 3'd6;
    #2 check("dual_a", {va[0], rd_a[0]}, 9'h111);
    check("dual_b", {vb[0], rd_b[0]}, 9'h122);
    raddr_a = 3'd6;
    #1 check("same_a", {va[0], rd_a[0]}, 9'h122);
    check("same_b", {vb[0], rd_b[0]}, 9'h122);
    check("d6_addr6_oor", {va[2], rd_a[2]}, 9'h000);

    // Clear beats a simultaneous write.
    step(); we = 1'b1; waddr = 3'd2; wdata = 8'h7F;
    step(); clr = 1'b1; wdata = 8'h55; raddr_a = 3'd2;
    #2 check("clr_cycle", {va[0], rd_a[0]}, 9'h17F);
    step(); clr = 1'b0; we = 1'b0; raddr_b = 3'd3;
    #2 check("clr_after_a", {va[0], rd_a[0]}, 9'h000);
    check("clr_after_b", {vb[0], rd_b[0]}, 9'h000);

    // Zero word and out-of-range write.
    step(); we = 1'b1; waddr = 3'd0; wdata = 8'hFF;
    step(); waddr = 3'd7; wdata = 8'h33; raddr_a = 3'd0;
    #2 check("zr_read0", {va[1], rd_a[1]}, 9'h100);
    check("plain_read0", {va[0], rd_a[0]}, 9'h1FF);
    step(); we = 1'b0; raddr_a = 3'd7; raddr_b = 3'd0;
    #2 check("d6_oor_read", {va[2], rd_a[2]}, 9'h000);
    check("plain_read7", {va[0], rd_a[0]}, 9'h133);
    check("zr_read0_b",  {vb[1], rd_b[1]}, 9'h100);

    // Reset lands in a write cycle.
    step(); we = 1'b1; waddr = 3'd4; wdata = 8'h99; raddr_a = 3'd4;
    #2 rst_n = 1'b0;
    step();
    step(); rst_n = 1'b1; we = 1'b0;
    #2 check("rst_mid_write", {va[0], rd_a[0]}, 9'h000);

    // Randomized traffic with occasional clears and reset pulses.
    for (int n = 0; n < 400; n++) begin
      step();
      rst_n   = 1'b1;
      we      = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 19) == 0);
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 8'($urandom);
      raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr_b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
      end
    end

    step();
    rst_n = 1'b1; we = 1'b0; clr = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
